// File: rtl/control_pulp_pkg.sv
// Shared types and constants for the external L2 AXI arbiter: AXI4 channel
// structs, controller state encoding and the legal L2 address window.
package control_pulp_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_ID_W   = 4;

  localparam logic [31:0] L2_RANGE_START = 32'h1C00_0000;
  localparam logic [31:0] L2_RANGE_END   = 32'h1C08_0000;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ADDR_CHK,
    ARB_WR_ADDR_DATA,
    ARB_WR_RESP,
    ARB_RD_ADDR,
    ARB_RD_DATA,
    ARB_DONE
  } arb_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    resp_t               resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    resp_t                 resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

  // Inclusive window test; operands are zero-extended so any AddrWidth up to 64 works.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] lo,
                                         input logic [63:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/axi_ext_rr_arb.sv
// Round-robin requester selection with a one-hot grant. The pointer names the
// highest-priority index and moves past the winner whenever a grant is taken.
module axi_ext_rr_arb #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr_q) + 32'(i)) % NumReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/axi_ext_l2_arbiter.sv
// Shares one external AXI4 master port among NumReq simple req/gnt requesters,
// one single-beat transaction at a time, with a local DECERR for non-L2 addresses.
//
// state            | meaning
// IDLE             | waiting for requests; grants one round-robin and latches it
// ADDR_CHK         | decide L2 window hit (AXI write/read) or local DECERR
// WR_ADDR_DATA     | AW and W offered together, each retired on its own ready
// WR_RESP          | waiting for B
// RD_ADDR          | AR offered until accepted
// RD_DATA          | waiting for R
// DONE             | completion pulse to the latched requester
module axi_ext_l2_arbiter #(
  parameter int unsigned          NumReq     = 2,
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 64,
  parameter logic [AddrWidth-1:0] RangeStart = control_pulp_pkg::L2_RANGE_START,
  parameter logic [AddrWidth-1:0] RangeEnd   = control_pulp_pkg::L2_RANGE_END,
  parameter type                  axi_req_t  = control_pulp_pkg::axi_req_t,
  parameter type                  axi_resp_t = control_pulp_pkg::axi_resp_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic [1:0]                            resp_o,
  output axi_req_t                              axi_req_o,
  input  axi_resp_t                             axi_rsp_i
);

  import control_pulp_pkg::*;

  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [2:0]  AxSize = 3'($clog2(DataWidth / 8));

  arb_state_e               state_q, state_d;
  logic [IdxW-1:0]          idx_q;
  logic                     we_q;
  logic [AddrWidth-1:0]     addr_q;
  logic [DataWidth-1:0]     wdata_q;
  logic [DataWidth/8-1:0]   be_q;
  logic [DataWidth-1:0]     rdata_q;
  logic [1:0]               resp_q;
  logic                     aw_done_q, w_done_q;
  logic                     in_range;
  logic                     arb_en;
  logic [NumReq-1:0]        arb_gnt;
  logic [IdxW-1:0]          arb_idx;

  assign arb_en   = (state_q == ARB_IDLE) && !rst_i;
  assign in_range = addr_in_range(64'(addr_q), 64'(RangeStart), 64'(RangeEnd));

  axi_ext_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) i_rr_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (arb_en),
    .req_i  (req_i),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:         if (|req_i) state_d = ARB_ADDR_CHK;
      ARB_ADDR_CHK: begin
        if (!in_range)  state_d = ARB_DONE;
        else if (we_q)  state_d = ARB_WR_ADDR_DATA;
        else            state_d = ARB_RD_ADDR;
      end
      ARB_WR_ADDR_DATA: if ((aw_done_q || axi_rsp_i.aw_ready) && (w_done_q || axi_rsp_i.w_ready))
                          state_d = ARB_WR_RESP;
      ARB_WR_RESP:      if (axi_rsp_i.b_valid) state_d = ARB_DONE;
      ARB_RD_ADDR:      if (axi_rsp_i.ar_ready) state_d = ARB_RD_DATA;
      ARB_RD_DATA:      if (axi_rsp_i.r_valid) state_d = ARB_DONE;
      ARB_DONE:         state_d = ARB_IDLE;
      default:          state_d = ARB_IDLE;
    endcase
  end

  // Transaction context and completion data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: if (|req_i) begin
          idx_q   <= arb_idx;
          we_q    <= we_i[arb_idx];
          addr_q  <= addr_i[arb_idx];
          wdata_q <= wdata_i[arb_idx];
          be_q    <= be_i[arb_idx];
          rdata_q <= '0;
          resp_q  <= RESP_OKAY;
        end
        ARB_ADDR_CHK: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (!in_range) resp_q <= RESP_DECERR;
        end
        ARB_WR_ADDR_DATA: begin
          if (axi_rsp_i.aw_ready) aw_done_q <= 1'b1;
          if (axi_rsp_i.w_ready)  w_done_q  <= 1'b1;
        end
        ARB_WR_RESP: if (axi_rsp_i.b_valid) resp_q <= axi_rsp_i.b.resp;
        ARB_RD_DATA: if (axi_rsp_i.r_valid) begin
          rdata_q <= axi_rsp_i.r.data;
          resp_q  <= axi_rsp_i.r.resp;
        end
        default: ;
      endcase
    end
  end

  // Payload fields come straight from registers, so they hold until handshake.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = AxSize;
    axi_req_o.aw.burst = BURST_INCR;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = AxSize;
    axi_req_o.ar.burst = BURST_INCR;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    gnt_o              = '0;
    rvalid_o           = '0;
    case (state_q)
      ARB_IDLE:         if (!rst_i) gnt_o = arb_gnt;
      ARB_WR_ADDR_DATA: begin
        axi_req_o.aw_valid = !aw_done_q;
        axi_req_o.w_valid  = !w_done_q;
      end
      ARB_WR_RESP:      axi_req_o.b_ready  = 1'b1;
      ARB_RD_ADDR:      axi_req_o.ar_valid = 1'b1;
      ARB_RD_DATA:      axi_req_o.r_ready  = 1'b1;
      ARB_DONE:         if (!rst_i) rvalid_o[idx_q] = 1'b1;
      default: ;
    endcase
  end

  assign rdata_o = rdata_q;
  assign resp_o  = resp_q;

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.r.id, axi_rsp_i.r.last};

endmodule

// File: tb/tb_axi_ext_l2_arbiter.sv
// Directed bench for axi_ext_l2_arbiter with a small single-outstanding AXI
// slave model (memory, optional AW stall and R hold).
module tb_axi_ext_l2_arbiter;
  import control_pulp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        req = '0, we = '0;
  logic [1:0][31:0]  addr = '0;
  logic [1:0][63:0]  wdata = '0;
  logic [1:0][7:0]   be = '0;
  logic [1:0]        gnt, rvalid;
  logic [63:0]       rdata;
  logic [1:0]        resp;
  axi_req_t          axi_req;
  axi_resp_t         axi_rsp;

  axi_ext_l2_arbiter dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .be_i      (be),
    .gnt_o     (gnt),
    .rvalid_o  (rvalid),
    .rdata_o   (rdata),
    .resp_o    (resp),
    .axi_req_o (axi_req),
    .axi_rsp_i (axi_rsp)
  );

  // ---------------- slave model ----------------
  int          aw_stall = 0;
  logic        r_hold   = 1'b0;
  int          aw_wait  = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_valid_s = 1'b0, r_valid_s = 1'b0;
  logic [31:0] aw_addr_s = '0;
  logic [63:0] w_data_s = '0, r_data_s = '0;
  logic [63:0] mem [logic [31:0]];
  axi_ax_t     last_aw = '0, last_ar = '0;
  logic [7:0]  last_strb = '0;
  logic        last_wlast = 1'b0;
  int          n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_ar_hs = 0;

  always_comb begin
    axi_rsp          = '0;
    axi_rsp.aw_ready = (aw_wait >= aw_stall);
    axi_rsp.w_ready  = 1'b1;
    axi_rsp.ar_ready = 1'b1;
    axi_rsp.b_valid  = b_valid_s;
    axi_rsp.b.resp   = RESP_OKAY;
    axi_rsp.r_valid  = r_valid_s && !r_hold;
    axi_rsp.r.data   = r_data_s;
    axi_rsp.r.resp   = RESP_OKAY;
    axi_rsp.r.last   = 1'b1;
  end

  wire aw_hs = axi_req.aw_valid && axi_rsp.aw_ready;
  wire w_hs  = axi_req.w_valid  && axi_rsp.w_ready;
  wire b_hs  = axi_req.b_ready  && axi_rsp.b_valid;
  wire ar_hs = axi_req.ar_valid && axi_rsp.ar_ready;
  wire r_hs  = axi_req.r_ready  && axi_rsp.r_valid;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_valid_s <= 1'b0; r_valid_s <= 1'b0; aw_wait <= 0;
    end else begin
      if (axi_req.aw_valid && !aw_hs) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= axi_req.aw.addr; last_aw <= axi_req.aw; n_aw_hs <= n_aw_hs + 1; end
      if (w_hs) begin
        w_got <= 1'b1; w_data_s <= axi_req.w.data;
        last_strb <= axi_req.w.strb; last_wlast <= axi_req.w.last; n_w_hs <= n_w_hs + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[aw_hs ? axi_req.aw.addr : aw_addr_s] = w_hs ? axi_req.w.data : w_data_s;
        b_valid_s <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_hs) begin b_valid_s <= 1'b0; n_b_hs <= n_b_hs + 1; end
      if (ar_hs) begin
        r_valid_s <= 1'b1; last_ar <= axi_req.ar; n_ar_hs <= n_ar_hs + 1;
        r_data_s  <= mem.exists(axi_req.ar.addr) ? mem[axi_req.ar.addr] : 64'h0;
      end
      if (r_hs) r_valid_s <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  int n_aw_vcyc = 0, n_w_vcyc = 0, n_rv = 0, n_dbl = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (axi_req.aw_valid) n_aw_vcyc <= n_aw_vcyc + 1;
    if (axi_req.w_valid)  n_w_vcyc  <= n_w_vcyc + 1;
    if (|rvalid)          n_rv      <= n_rv + 1;
    if ($countones(gnt) > 1) n_dbl  <= n_dbl + 1;
  end

  // ---------------- checking ----------------
  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic txn(input int r, input logic w, input logic [31:0] a, input logic [63:0] d,
                     input logic [7:0] b, output logic [63:0] rd, output logic [1:0] rs,
                     output int lat);
    int g, t;
    @(negedge clk);
    req[r] = 1'b1; we[r] = w; addr[r] = a; wdata[r] = d; be[r] = b;
    #1;
    t = 0;
    while (!gnt[r] && t < 20) begin @(negedge clk); #1; t++; end
    g = cyc;
    @(posedge clk); #1;
    req[r] = 1'b0;
    lat = -1; rd = 'x; rs = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (rvalid[r]) begin rd = rdata; rs = resp; lat = cyc - g; break; end
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [1:0]  rs;
    int lat, b_aw, b_w, b_b, b_ar, b_awv, b_wv, b_rv, b_dbl, t;
    int order [4];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_axi", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", 64'(resp), 64'(RESP_OKAY));
    @(negedge clk); rst = 1'b0;

    // requester 0 write
    b_aw = n_aw_hs; b_b = n_b_hs;
    txn(0, 1'b1, 32'h1C00_0000, 64'hCAFE_CAFE, 8'hFF, rd, rs, lat);
    chk("wr0_resp", 64'(rs), 64'(RESP_OKAY));
    chk("wr0_lat", 64'(lat), 4);
    chk("wr0_rdata", rd, 0);
    chk("wr0_aw_cnt", 64'(n_aw_hs - b_aw), 1);
    chk("wr0_b_cnt", 64'(n_b_hs - b_b), 1);
    chk("wr0_aw_size", 64'(last_aw.size), 3);
    chk("wr0_aw_len", 64'(last_aw.len), 0);
    chk("wr0_aw_burst", 64'(last_aw.burst), 1);
    chk("wr0_aw_id", 64'(last_aw.id), 0);
    chk("wr0_w_last", 64'(last_wlast), 1);
    chk("wr0_w_strb", 64'(last_strb), 64'hFF);

    // requester 1 read back
    txn(1, 1'b0, 32'h1C00_0000, 64'h0, 8'h00, rd, rs, lat);
    chk("rd1_rdata", rd, 64'hCAFE_CAFE);
    chk("rd1_resp", 64'(rs), 64'(RESP_OKAY));
    chk("rd1_lat", 64'(lat), 4);
    chk("rd1_ar_size", 64'(last_ar.size), 3);

    // upper boundary inclusive, one past is local DECERR
    b_aw = n_aw_hs;
    txn(0, 1'b1, 32'h1C08_0000, 64'h1111, 8'hFF, rd, rs, lat);
    chk("hi_in_resp", 64'(rs), 64'(RESP_OKAY));
    chk("hi_in_aw_cnt", 64'(n_aw_hs - b_aw), 1);
    b_awv = n_aw_vcyc;
    txn(1, 1'b1, 32'h1C08_0008, 64'h2222, 8'hFF, rd, rs, lat);
    chk("hi_out_resp", 64'(rs), 64'(RESP_DECERR));
    chk("hi_out_lat", 64'(lat), 2);
    chk("hi_out_rdata", rd, 0);
    chk("hi_out_aw_vcyc", 64'(n_aw_vcyc - b_awv), 0);

    // both requesters hold for four transactions
    b_rv = n_rv; b_dbl = n_dbl;
    @(negedge clk);
    req = 2'b11; we = 2'b11; addr[0] = 32'h1C00_0100; addr[1] = 32'h1C00_0200;
    wdata[0] = 64'hA0; wdata[1] = 64'hB1; be = {8'hFF, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      #1;
      t = 0;
      while (gnt == 2'b00 && t < 20) begin @(negedge clk); #1; t++; end
      order[k] = (gnt == 2'b01) ? 0 : (gnt == 2'b10) ? 1 : 9;
      @(posedge clk);
      if (k == 3) begin #1; req = 2'b00; end
      else @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("rr_g0", 64'(order[0]), 0);
    chk("rr_g1", 64'(order[1]), 1);
    chk("rr_g2", 64'(order[2]), 0);
    chk("rr_g3", 64'(order[3]), 1);
    chk("rr_dbl", 64'(n_dbl - b_dbl), 0);
    chk("rr_done_cnt", 64'(n_rv - b_rv), 4);

    // AW stalled five cycles, W accepted immediately
    aw_stall = 5;
    b_awv = n_aw_vcyc; b_wv = n_w_vcyc; b_b = n_b_hs; b_w = n_w_hs;
    txn(0, 1'b1, 32'h1C00_0010, 64'h5555, 8'h0F, rd, rs, lat);
    aw_stall = 0;
    chk("stall_w_vcyc", 64'(n_w_vcyc - b_wv), 1);
    chk("stall_aw_vcyc", 64'(n_aw_vcyc - b_awv), 6);
    chk("stall_w_cnt", 64'(n_w_hs - b_w), 1);
    chk("stall_b_cnt", 64'(n_b_hs - b_b), 1);
    chk("stall_resp", 64'(rs), 64'(RESP_OKAY));
    chk("stall_lat", 64'(lat), 9);

    // unaligned address forwarded unchanged
    txn(1, 1'b0, 32'h1C00_0004, 64'h0, 8'h00, rd, rs, lat);
    chk("unal_ar_addr", 64'(last_ar.addr), 64'h1C00_0004);
    chk("unal_resp", 64'(rs), 64'(RESP_OKAY));

    // below window read
    b_ar = n_ar_hs;
    txn(0, 1'b0, 32'h1BFF_FFF8, 64'h0, 8'h00, rd, rs, lat);
    chk("lo_out_resp", 64'(rs), 64'(RESP_DECERR));
    chk("lo_out_lat", 64'(lat), 2);
    chk("lo_out_ar_cnt", 64'(n_ar_hs - b_ar), 0);

    // reset while waiting in RD_DATA
    r_hold = 1'b1;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h1C00_0000;
    #1;
    t = 0;
    while (!gnt[0] && t < 20) begin @(negedge clk); #1; t++; end
    @(posedge clk); #1;
    req[0] = 1'b0;
    t = 0;
    while (!axi_req.r_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("abort_in_rd_data", 64'(axi_req.r_ready), 1);
    b_rv = n_rv;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rvalid", 64'(rvalid), 0);
    chk("abort_gnt", 64'(gnt), 0);
    chk("abort_axi", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}), 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_resp", 64'(resp), 64'(RESP_OKAY));
    rst = 1'b0;
    r_hold = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_pulse", 64'(n_rv - b_rv), 0);
    txn(0, 1'b0, 32'h1C00_0000, 64'h0, 8'h00, rd, rs, lat);
    chk("post_rst_rdata", rd, 64'hCAFE_CAFE);
    chk("post_rst_lat", 64'(lat), 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
